// File: rtl/line_buf_5_pkg.sv
// ============================================================================
// Module   : line_buf_5_pkg
// Purpose  : Shared constants for the five-line vertical window generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_buf_5_pkg;

    localparam int         LB_TAPS    = 5;
    localparam int         LB_LINES   = LB_TAPS - 1;
    localparam logic [7:0] LB_NEUTRAL = 8'hFF;
    localparam int         LB_CNT_W   = $clog2(LB_TAPS);

endpackage

`default_nettype wire

// File: rtl/line_buf_5_line_ram.sv
// ============================================================================
// Module   : line_ram
// Purpose  : Single-port line store, read-first, registered read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_ram
    import line_buf_5_pkg::*;
#(
    parameter  int DEPTH = 640,
    parameter  int W     = 8,
    localparam int A_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_we,
    input  logic [A_W-1:0] i_addr,
    input  logic [W-1:0]   i_wdata,
    output logic [W-1:0]   o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read sees the old contents when the same address is written this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/line_buf_5.sv
// ============================================================================
// Module   : line_buf_5
// Purpose  : Emits the current pixel plus the four lines above it, same column.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buf_5
    import line_buf_5_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              den_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic [DATA_W-1:0] data_out4,
    output logic              den_out
);

    localparam int c_COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [c_COL_W-1:0]  r_col, w_col;
    logic [1:0]          r_wp, w_wp;
    logic [LB_CNT_W-1:0] r_lcnt, w_lcnt;

    logic                r_den_d1;
    logic [DATA_W-1:0]   r_data_d1;
    logic [1:0]          r_wp_d1;
    logic [LB_CNT_W-1:0] r_lcnt_d1;

    logic [DATA_W-1:0]                w_ram_q [LB_LINES];
    logic [LB_TAPS-1:0][DATA_W-1:0]   w_tap;
    logic [LB_TAPS-1:0][DATA_W-1:0]   r_tap;
    logic                             r_den_out;

    // frame_start takes effect before the pixel presented with it
    always_comb begin
        w_col  = r_col;
        w_wp   = r_wp;
        w_lcnt = r_lcnt;
        if (frame_start) begin
            w_col  = '0;
            w_wp   = '0;
            w_lcnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_wp   <= '0;
            r_lcnt <= '0;
        end else if (den_in && (w_col == c_COL_W'(IMG_WIDTH - 1))) begin
            r_col  <= '0;
            r_wp   <= w_wp + 2'd1;
            r_lcnt <= (w_lcnt == LB_CNT_W'(LB_LINES)) ? w_lcnt : w_lcnt + LB_CNT_W'(1);
        end else if (den_in) begin
            r_col  <= w_col + c_COL_W'(1);
            r_wp   <= w_wp;
            r_lcnt <= w_lcnt;
        end else begin
            r_col  <= w_col;
            r_wp   <= w_wp;
            r_lcnt <= w_lcnt;
        end
    end

    generate
        for (genvar g = 0; g < LB_LINES; g++) begin : g_ram
            line_ram #(
                .DEPTH (IMG_WIDTH),
                .W     (DATA_W)
            ) u_line_ram (
                .clk     (clk),
                .rst     (rst),
                .i_we    (den_in && (w_wp == 2'(g))),
                .i_addr  (w_col),
                .i_wdata (data_in),
                .o_rdata (w_ram_q[g])
            );
        end
    endgenerate

    // Line state travels with the pixel so a wrap never disturbs its own taps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_den_d1  <= 1'b0;
            r_data_d1 <= '0;
            r_wp_d1   <= '0;
            r_lcnt_d1 <= '0;
        end else begin
            r_den_d1  <= den_in;
            r_data_d1 <= data_in;
            r_wp_d1   <= w_wp;
            r_lcnt_d1 <= w_lcnt;
        end
    end

    assign w_tap[LB_TAPS-1] = r_data_d1;

    generate
        for (genvar k = 1; k < LB_TAPS; k++) begin : g_tap
            logic [1:0] w_sel;
            assign w_sel = r_wp_d1 - 2'(k);
            assign w_tap[LB_TAPS-1-k] = (r_lcnt_d1 >= LB_CNT_W'(k)) ? w_ram_q[w_sel]
                                                                   : DATA_W'(LB_NEUTRAL);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap     <= '0;
            r_den_out <= 1'b0;
        end else begin
            r_tap     <= w_tap;
            r_den_out <= r_den_d1;
        end
    end

    assign data_out0 = r_tap[0];
    assign data_out1 = r_tap[1];
    assign data_out2 = r_tap[2];
    assign data_out3 = r_tap[3];
    assign data_out4 = r_tap[4];
    assign den_out   = r_den_out;

endmodule

`default_nettype wire

// File: tb/tb_line_buf_5.sv
// ============================================================================
// Module   : tb_line_buf_5
// Purpose  : Table-driven, scoreboard-checked bench for line_buf_5 (width 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_buf_5;

    localparam int W = 4;

    typedef logic [4:0][7:0] taps_t;
    typedef struct {
        logic       fs;
        logic       den;
        logic [7:0] data;
        taps_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       den_in = 1'b1;
    logic [7:0] data_in = 8'hAB;
    logic [7:0] data_out0, data_out1, data_out2, data_out3, data_out4;
    logic       den_out;

    vec_t  tbl[$];
    taps_t sb[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    int    m_line = 0;
    int    m_col  = 0;
    logic [7:0] hist [0:31][0:3];
    logic  sh1 = 1'b0, sh2 = 1'b0, mon_en = 1'b0;

    always #5 clk = ~clk;

    line_buf_5 #(
        .IMG_WIDTH (W),
        .DATA_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .den_in      (den_in),
        .data_in     (data_in),
        .data_out0   (data_out0),
        .data_out1   (data_out1),
        .data_out2   (data_out2),
        .data_out3   (data_out3),
        .data_out4   (data_out4),
        .den_out     (den_out)
    );

    // Reference model: remembers every line of the frame, tap k = line n-k same column
    function automatic void add(input logic fs, input logic den, input logic [7:0] d);
        vec_t v;
        v.fs   = fs;
        v.den  = den;
        v.data = d;
        v.exp  = '0;
        if (fs) begin
            m_line = 0;
            m_col  = 0;
        end
        if (den) begin
            v.exp[4] = d;
            for (int k = 1; k < 5; k++)
                v.exp[4-k] = (m_line >= k) ? hist[m_line-k][m_col] : 8'hFF;
            hist[m_line][m_col] = d;
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_line++;
            end
        end
        tbl.push_back(v);
    endfunction

    function automatic void add_line(input int base, input int stride);
        for (int c = 0; c < W; c++) add(1'b0, 1'b1, 8'(base + stride * c));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            sh1 <= 1'b0;
            sh2 <= 1'b0;
        end else begin
            sh1 <= den_in;
            sh2 <= sh1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (den_out !== sh2) begin
                n_miss++;
                $display("FAIL den_out @%0t: got %b expected %b", $time, den_out, sh2);
            end
            if (sh2) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL taps @%0t: output with empty scoreboard", $time);
                end else begin
                    taps_t e;
                    taps_t a;
                    e = sb.pop_front();
                    a = {data_out4, data_out3, data_out2, data_out1, data_out0};
                    if (a !== e) begin
                        n_miss++;
                        $display("FAIL taps @%0t: got %h expected %h", $time, a, e);
                    end
                end
            end
        end
    end

    initial begin
        // after reset, pixels without frame_start form line 0
        add_line(8'h05, 1);
        // fill: constant lines 10..60
        add(1'b1, 1'b0, 8'h00);
        for (int l = 0; l < 6; l++) add_line((l + 1) * 10, 0);
        // column alignment, frame_start coincident with first pixel
        for (int l = 0; l < 6; l++)
            for (int c = 0; c < W; c++)
                add((l == 0 && c == 0), 1'b1, 8'(16 * l + c));
        // gapped line 4; idle data must never be stored
        add(1'b1, 1'b0, 8'h00);
        for (int l = 0; l < 4; l++) add_line((l + 1) * 10, 0);
        for (int c = 0; c < W; c++) begin
            add(1'b0, 1'b1, 8'(50 + c));
            repeat ($urandom_range(1, 3)) add(1'b0, 1'b0, 8'hEE);
        end
        add_line(60, 0);
        // mid-frame restart at line 3 col 1, stale lines must stay masked
        add(1'b1, 1'b0, 8'h00);
        for (int l = 0; l < 3; l++) add_line(8'hA0 + 16 * l, 1);
        add(1'b0, 1'b1, 8'hD0);
        add(1'b1, 1'b0, 8'h00);
        add(1'b0, 1'b1, 8'h77);
        add_line(8'h90, 1);
        add(1'b1, 1'b1, 8'h55);
        add(1'b0, 1'b1, 8'h56);

        // reset held with den_in high
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (den_out !== 1'b0 ||
                {data_out4, data_out3, data_out2, data_out1, data_out0} !== 40'd0) begin
                n_miss++;
                $display("FAIL reset: got den=%b taps=%h expected 0",
                         den_out, {data_out4, data_out3, data_out2, data_out1, data_out0});
            end
        end
        rst    = 1'b0;
        den_in = 1'b0;
        mon_en = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            frame_start = tbl[i].fs;
            den_in      = tbl[i].den;
            data_in     = tbl[i].data;
            if (tbl[i].den) sb.push_back(tbl[i].exp);
        end
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        den_in      = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending outputs expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
